// File: rtl/iter_shift_right_pkg.sv
// Shared definitions for the iterative right shifter: default widths and FSM state encoding.
package iter_shift_right_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/iter_shift_right_step.sv
// One-bit right step: drops bit 0 and inserts the fill bit at the MSB, built bit by bit.
module shift_right_1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             fill,
    output logic [WIDTH-1:0] out
);

    genvar i;
    generate
        for (i = 0; i < WIDTH - 1; i++) begin : g_bit
            assign out[i] = in[i+1];
        end
    endgenerate

    assign out[WIDTH-1] = fill;

endmodule

// File: rtl/iter_shift_right.sv
// Multi-cycle right shifter (srl/sra/srlv/srav): one bit per clock, Moore busy/done.
module iter_shift_right
    import iter_shift_right_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] cnt;
    logic               fill;

    shift_right_1 #(.WIDTH(WIDTH)) u_step (
        .in   (shift_q),
        .fill (fill),
        .out  (step_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt     <= '0;
            fill    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= operand;
                        cnt     <= shamt;
                        // Fill is frozen at acceptance so sra keeps replicating the original sign.
                        fill    <= arith & operand[WIDTH-1];
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shift_q <= step_out;
                        cnt     <= cnt - SHAMT_W'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = shift_q;

endmodule

// File: tb/tb_iter_shift_right.sv
// Self-checking bench for iter_shift_right: vector table plus multi-cycle corner sequences.
module tb_iter_shift_right;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    iter_shift_right #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .operand (operand),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, scramble inputs after acceptance, and check latency, busy span, result, hold.
    task automatic run_op(input string name, input logic [31:0] op, input logic [4:0] sh,
                          input logic ar, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int nbusy;
        operand = op;
        shamt   = sh;
        arith   = ar;
        start   = 1'b1;
        step();
        start   = 1'b0;
        operand = ~op;
        shamt   = ~sh;
        arith   = ~ar;
        lat     = 1;
        nbusy   = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
        if (busy) nbusy++;
        check({name, " done_seen"}, 32'(done), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy_cycles"}, 32'(nbusy), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        step();
        check({name, " done_single"}, 32'(done), 32'd0);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        check({name, " result_hold"}, result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        int   ndone;
        int   lat;
        logic [31:0] first_res;

        vecs[0] = '{32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000, 6};
        vecs[1] = '{32'h8000_0010, 5'd4,  1'b1, 32'hF800_0001, 6};
        vecs[2] = '{32'h8000_0010, 5'd4,  1'b0, 32'h0800_0001, 6};
        vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 2};
        vecs[4] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 33};
        vecs[5] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 33};
        vecs[6] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 2};
        vecs[7] = '{32'h8765_4321, 5'd8,  1'b1, 32'hFF87_6543, 10};
        vecs[8] = '{32'h7FFF_FFFF, 5'd1,  1'b1, 32'h3FFF_FFFF, 3};

        reset   = 1'b1;
        start   = 1'b1;
        operand = 32'hAAAA_AAAA;
        shamt   = 5'd3;
        arith   = 1'b1;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sh, vecs[i].ar,
                   vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Start pulsed mid-job must be dropped.
        operand = 32'h0000_FF00;
        shamt   = 5'd8;
        arith   = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        operand = 32'hDEAD_BEEF;
        shamt   = 5'd0;
        start   = 1'b1;
        step();
        start     = 1'b0;
        ndone     = 0;
        lat       = 3;
        first_res = 32'hx;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                if (ndone == 0) begin
                    check("ignored latency", 32'(lat), 32'd10);
                    first_res = result;
                end
                ndone++;
            end
            step();
            lat++;
        end
        check("ignored done_count", 32'(ndone), 32'd1);
        check("ignored result", first_res, 32'h0000_00FF);
        check("ignored final_result", result, 32'h0000_00FF);

        // Reset asserted in cycle c+3 of an shamt=10 job.
        operand = 32'hFFFF_0000;
        shamt   = 5'd10;
        arith   = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) ndone++;
            step();
        end
        check("midreset no_done", 32'(ndone), 32'd0);
        run_op("after_reset", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 6);

        // Start held high: re-accepted in the IDLE cycle right after done.
        operand = 32'h0000_0100;
        shamt   = 5'd2;
        arith   = 1'b0;
        start   = 1'b1;
        step();
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
        check("b2b first_latency", 32'(lat), 32'd4);
        check("b2b first_result", result, 32'h0000_0040);
        operand = 32'h8000_0002;
        shamt   = 5'd1;
        arith   = 1'b1;
        step();
        check("b2b idle_busy", 32'(busy), 32'd0);
        check("b2b idle_result", result, 32'h0000_0040);
        step();
        start = 1'b0;
        check("b2b reaccept_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
        check("b2b second_latency", 32'(lat), 32'd3);
        check("b2b second_result", result, 32'hC000_0001);
        step();
        step();
        check("b2b final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iter_shift_right.md
Name: iter_shift_right

Overview:
- Multi-cycle right shifter for the multicycle MIPS datapath; executes srl/sra/srlv/srav.
- Performs the direction opposite to the fixed branch-offset left-shift block: right shift by 0..31, one bit per clock.
- Sits beside the ALU; the control FSM starts it and stalls on busy until done, then writes result to the register file.
- Chosen over a combinational barrel shifter to keep gate-level area small.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, no other clock domains.
- start  in  1  request; sampled only while busy==0.
- operand  in  WIDTH  value to shift; captured on accepted start.
- shamt  in  SHAMT_W  shift amount; captured on accepted start.
- arith  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on accepted start.
- busy  out  1  high from the cycle after acceptance until the cycle done is high, inclusive.
- done  out  1  single-cycle completion pulse.
- result  out  WIDTH  shifted value; valid when done==1, held until the next accepted start.

Behaviour:
- States: IDLE, SHIFT, DONE (2-bit encoding).
- Reset (synchronous, active-high) applies at any time, including mid-operation:
  - state=IDLE, shift reg=0, cnt=0, fill bit=0, so result=0, busy=0, done=0.
  - Any in-flight operation is abandoned; no done pulse for it.
- IDLE:
  - start=1 at an edge -> reg<=operand, cnt<=shamt, fill<=arith & operand[WIDTH-1], state<=SHIFT.
  - start=0 -> stay in IDLE; result holds its last value.
- SHIFT, at each edge:
  - cnt!=0 -> reg<={fill, reg[WIDTH-1:1]}, cnt<=cnt-1.
  - cnt==0 -> state<=DONE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE. A new start is accepted only from IDLE.
- Latency: start sampled in cycle c -> done high in cycle c+shamt+2.
  - shamt=0 -> 2 cycles, result=operand.
  - shamt=31 -> 33 cycles.
- busy = (state!=IDLE). start while busy is ignored; no queuing, no error flag.
- Outputs: result is driven directly from reg, which is unchanged in DONE and IDLE. done and busy are decoded from registered state only (Moore).
- Operand, shamt and arith changing after acceptance have no effect on the operation in flight.
- Fill bit is latched once at acceptance, so a sign bit of 1 stays constant across all sra steps.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared header shift_defs.vh:
  - State encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH and SHAMT_W.
- Sub-module shift_right_1: combinational one-bit right step, inputs (in[WIDTH-1:0], fill), output out. Built gate-level in the same style as the existing fixed left-shift block.
- iter_shift_right instantiates one shift_right_1. It holds the FSM, the down-counter and the data and fill registers.

Test Plan:
- srl: operand=32'hF000_0000, shamt=4, arith=0 -> done in cycle c+6, result=32'h0F00_0000; busy high c+1..c+6.
- sra: operand=32'h8000_0010, shamt=4, arith=1 -> result=32'hF800_0001; with arith=0 -> 32'h0800_0001.
- Boundaries:
  - shamt=0, operand=32'h1234_5678 -> done at c+2, result=32'h1234_5678.
  - shamt=31, operand=32'h8000_0000, arith=1 -> done at c+33, result=32'hFFFF_FFFF.
- Ignored start: pulse start with operand=32'hDEAD_BEEF during an shamt=8 job -> first job completes unchanged; exactly one done pulse; the second request is dropped.
- Reset mid-operation: assert reset at c+3 of an shamt=10 job -> next cycle busy=0, done=0, result=0; no done follows; a fresh start then completes normally.
- Back-to-back: a start held high continuously is accepted again in the cycle after done (IDLE). Result stays stable between done and the next accepted start.
